// File: rtl/timer_pkg.sv
// Shared definitions for the timer AXI4-Lite register block: register map
// offsets, AXI response codes, bit positions and FSM state encodings.
// Optional feature macro: TIMER_IRQ_MASK_EN (adds the IER register at 0x10).
package timer_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_LOAD   = 8'h04;
    localparam logic [7:0] ADDR_COUNT  = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h0C;
    localparam logic [7:0] ADDR_IER    = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_STOP_BIT   = 1;
    localparam int STATUS_PEND_BIT = 0;
    localparam int IER_EN_BIT      = 0;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    // True for word-aligned offsets that hit a real register.
    function automatic logic addr_mapped(input logic [7:0] addr);
        logic hit;
        hit = (addr == ADDR_CTRL) || (addr == ADDR_LOAD) ||
              (addr == ADDR_COUNT) || (addr == ADDR_STATUS);
`ifdef TIMER_IRQ_MASK_EN
        hit = hit || (addr == ADDR_IER);
`endif
        return hit;
    endfunction

endpackage

// File: rtl/timer_axil_regs.sv
// AXI4-Lite slave register file in front of the timer core.
// Converts bus writes into start/stop pulses and the reload value, exposes
// the live count and the sticky W1C interrupt-pending bit, drives irq_o.
// Optional feature macro: TIMER_IRQ_MASK_EN (IER at 0x10 gates irq_o).
module timer_axil_regs
    import timer_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] LOAD_RST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              start_o,
    output logic              stop_o,
    output logic [31:0]       load_val_o,
    input  logic [31:0]       cur_count_i,
    input  logic              core_irq_i,
    output logic              irq_o
);

    // Low address bits are ignored: every register is word-aligned.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    // Keeps all ready outputs low until the first clock after reset release.
    logic en_q;
    // Ready gating register: set once out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) en_q <= 1'b0;
        else       en_q <= 1'b1;
    end

    // ---------------- write channel ----------------
    wr_state_e   wr_state_q, wr_state_d;
    logic        aw_held_q, w_held_q;
    logic [7:0]  wr_addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q;
    logic        aw_hs, w_hs, commit;

    assign aw_hs  = s_awvalid & s_awready;
    assign w_hs   = s_wvalid & s_wready;
    assign commit = (wr_state_q == W_IDLE) & aw_held_q & w_held_q;

    // Write FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) wr_state_q <= W_IDLE;
        else       wr_state_q <= wr_state_d;
    end

    // Write FSM next state: respond after commit, return once the master takes it.
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE: if (commit)   wr_state_d = W_RESP;
            W_RESP: if (s_bready) wr_state_d = W_IDLE;
            default:              wr_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs: each of AW/W is taken once, nothing new while responding.
    always_comb begin
        s_awready = en_q & (wr_state_q == W_IDLE) & ~aw_held_q;
        s_wready  = en_q & (wr_state_q == W_IDLE) & ~w_held_q;
        s_bvalid  = (wr_state_q == W_RESP);
        s_bresp   = bresp_q;
    end

    // Capture AW and W independently; release both on commit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            wr_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (commit)     aw_held_q <= 1'b0;
            else if (aw_hs) aw_held_q <= 1'b1;
            if (commit)     w_held_q  <= 1'b0;
            else if (w_hs)  w_held_q  <= 1'b1;
            if (aw_hs) wr_addr_q <= 8'({s_awaddr[ADDR_W-1:2], 2'b00});
            if (w_hs) begin
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            if (commit) bresp_q <= addr_mapped(wr_addr_q) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // ---------------- registers ----------------
    logic       wr_ctrl, wr_load, wr_w1c;
    logic       start_q, stop_q, run_q;
    logic       irq_prev_q, pend_q, pend_d, irq_o_q, irq_set;
    logic [7:0] load_byte_q [4];

    assign wr_ctrl = commit & (wr_addr_q == ADDR_CTRL);
    assign wr_load = commit & (wr_addr_q == ADDR_LOAD);
    assign wr_w1c  = commit & (wr_addr_q == ADDR_STATUS) &
                     wdata_q[STATUS_PEND_BIT] & wstrb_q[0];
    assign irq_set = core_irq_i & ~irq_prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_load
            // LOAD byte lane, written only when its strobe is set.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)                      load_byte_q[gi] <= LOAD_RST[gi*8 +: 8];
                else if (wr_load && wstrb_q[gi]) load_byte_q[gi] <= wdata_q[gi*8 +: 8];
            end
        end
    endgenerate

    assign load_val_o = {load_byte_q[3], load_byte_q[2], load_byte_q[1], load_byte_q[0]};

    // CTRL pulses and RUN flag; STOP takes priority when both bits are written.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            start_q <= wr_ctrl & wdata_q[CTRL_START_BIT] & ~wdata_q[CTRL_STOP_BIT];
            stop_q  <= wr_ctrl & wdata_q[CTRL_STOP_BIT];
            if (wr_ctrl && wdata_q[CTRL_STOP_BIT])       run_q <= 1'b0;
            else if (wr_ctrl && wdata_q[CTRL_START_BIT]) run_q <= 1'b1;
        end
    end

    assign start_o = start_q;
    assign stop_o  = stop_q;

    // Sticky pending bit: a fresh core edge beats a simultaneous clear.
    always_comb begin
        pend_d = pend_q;
        if (irq_set)     pend_d = 1'b1;
        else if (wr_w1c) pend_d = 1'b0;
    end

`ifdef TIMER_IRQ_MASK_EN
    logic ier_en_q;
    // Interrupt enable register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ier_en_q <= 1'b0;
        else if (commit && (wr_addr_q == ADDR_IER) && wstrb_q[0])
            ier_en_q <= wdata_q[IER_EN_BIT];
    end
`endif

    // Edge detect, pending bit and the registered system interrupt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_prev_q <= 1'b0;
            pend_q     <= 1'b0;
            irq_o_q    <= 1'b0;
        end else begin
            irq_prev_q <= core_irq_i;
            pend_q     <= pend_d;
`ifdef TIMER_IRQ_MASK_EN
            irq_o_q    <= pend_q & ier_en_q;
`else
            irq_o_q    <= pend_q;
`endif
        end
    end

    assign irq_o = irq_o_q;

    // ---------------- read channel ----------------
    rd_state_e   rd_state_q, rd_state_d;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data_d, rdata_q;
    logic [1:0]  rd_resp_d, rresp_q;
    logic        ar_hs;

    assign rd_addr = 8'({s_araddr[ADDR_W-1:2], 2'b00});
    assign ar_hs   = s_arvalid & s_arready;

    // Read data mux; unmapped offsets return zero with SLVERR.
    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_OKAY;
        case (rd_addr)
            ADDR_CTRL:   rd_data_d = {31'b0, run_q};
            ADDR_LOAD:   rd_data_d = load_val_o;
            ADDR_COUNT:  rd_data_d = cur_count_i;
            ADDR_STATUS: rd_data_d = {31'b0, pend_q};
`ifdef TIMER_IRQ_MASK_EN
            ADDR_IER:    rd_data_d = {31'b0, ier_en_q};
`endif
            default:     rd_resp_d = RESP_SLVERR;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rd_state_q <= R_IDLE;
        else       rd_state_q <= rd_state_d;
    end

    // Read FSM next state: one beat per address, held until accepted.
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (ar_hs)    rd_state_d = R_DATA;
            R_DATA:  if (s_rready) rd_state_d = R_IDLE;
            default:               rd_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        s_arready = en_q & (rd_state_q == R_IDLE);
        s_rvalid  = (rd_state_q == R_DATA);
        s_rdata   = rdata_q;
        s_rresp   = rresp_q;
    end

    // Read data/response captured on address accept and held until taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_data_d;
            rresp_q <= rd_resp_d;
        end
    end

endmodule

// File: tb/tb_timer_axil_regs.sv
// Directed self-checking bench for timer_axil_regs.
// Build with TIMER_IRQ_MASK_EN defined to exercise the IER register.
module tb_timer_axil_regs;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  s_awaddr;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic [4:0]  s_araddr;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid, s_rready;
    logic        start_o, stop_o;
    logic [31:0] load_val_o;
    logic [31:0] cur_count_i;
    logic        core_irq_i;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    int stop_cnt  = 0;

    always #5 clk = ~clk;

    timer_axil_regs #(.ADDR_W(5), .LOAD_RST(32'h0)) dut (
        .clk(clk), .rstn(rstn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .start_o(start_o), .stop_o(stop_o), .load_val_o(load_val_o),
        .cur_count_i(cur_count_i), .core_irq_i(core_irq_i), .irq_o(irq_o)
    );

    // Count high cycles of the core pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (start_o) start_cnt++;
        if (stop_o)  stop_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_req(input logic [4:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit w_lead);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_wvalid = 1'b1; s_awvalid = !w_lead;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            tick(); n++;
            if (aw_hs) begin s_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin s_wvalid  = 1'b0; w_done  = 1; end
            if (!aw_done) s_awvalid = 1'b1;
        end
        if (!(aw_done && w_done)) begin
            checks++; failures++;
            $display("FAIL wr_req_timeout addr=%h got aw=%0d w=%0d expected 1 1", addr, aw_done, w_done);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
    endtask

    task automatic wr_resp(input int hold, output logic [1:0] resp, output bit stable);
        int n = 0;
        while (!s_bvalid && n < 20) begin tick(); n++; end
        if (!s_bvalid) begin
            checks++; failures++;
            $display("FAIL bvalid_timeout got 0 expected 1");
        end
        resp = s_bresp; stable = 1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!s_bvalid || s_bresp !== resp) stable = 0;
        end
        s_bready = 1'b1; tick(); s_bready = 1'b0;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit w_lead, output logic [1:0] resp);
        bit st;
        wr_req(addr, data, strb, w_lead);
        wr_resp(0, resp, st);
    endtask

    task automatic rd_req(input logic [4:0] addr);
        int n = 0;
        s_araddr = addr; s_arvalid = 1'b1;
        while (!s_arready && n < 20) begin tick(); n++; end
        if (!s_arready) begin
            checks++; failures++;
            $display("FAIL arready_timeout got 0 expected 1");
        end
        tick(); s_arvalid = 1'b0;
    endtask

    task automatic rd_resp(input int hold, output logic [31:0] data,
                           output logic [1:0] resp, output bit stable);
        int n = 0;
        while (!s_rvalid && n < 20) begin tick(); n++; end
        if (!s_rvalid) begin
            checks++; failures++;
            $display("FAIL rvalid_timeout got 0 expected 1");
        end
        data = s_rdata; resp = s_rresp; stable = 1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!s_rvalid || s_rdata !== data || s_rresp !== resp) stable = 0;
        end
        s_rready = 1'b1; tick(); s_rready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit st;
        rd_req(addr);
        rd_resp(0, data, resp, st);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, start_o, stop_o, irq_o} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl_outs got %b expected 00000000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, start_o, stop_o, irq_o});
        end
        checks++;
        if ({s_bresp, s_rresp} !== 4'b0000) begin
            failures++; $display("FAIL reset_resp got %b expected 0000", {s_bresp, s_rresp});
        end
        checks++;
        if (s_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got %h expected 00000000", s_rdata);
        end
        checks++;
        if (load_val_o !== 32'h0) begin
            failures++; $display("FAIL reset_load got %h expected 00000000", load_val_o);
        end
        rstn = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_load();
        logic [1:0] resp; logic [31:0] d;
        axi_write(5'h04, 32'hFFFF_FFF0, 4'hF, 0, resp);
        checks++;
        if (resp !== 2'b00) begin failures++; $display("FAIL load_bresp got %b expected 00", resp); end
        axi_read(5'h04, d, resp);
        checks++;
        if (d !== 32'hFFFF_FFF0) begin failures++; $display("FAIL load_read got %h expected fffffff0", d); end
        checks++;
        if (load_val_o !== 32'hFFFF_FFF0) begin failures++; $display("FAIL load_val_o got %h expected fffffff0", load_val_o); end
        axi_write(5'h04, 32'hAABB_CCDD, 4'b0101, 0, resp);
        axi_read(5'h06, d, resp);
        checks++;
        if (d !== 32'hFFBB_FFDD) begin failures++; $display("FAIL load_strobe got %h expected ffbbffdd", d); end
        $display("load: read %h resp %b", d, resp);
    endtask

    task automatic test_count();
        logic [1:0] resp; logic [31:0] d;
        cur_count_i = 32'h1234_5678;
        axi_read(5'h08, d, resp);
        checks++;
        if ({d, resp} !== {32'h1234_5678, 2'b00}) begin
            failures++; $display("FAIL count_read got %h/%b expected 12345678/00", d, resp);
        end
        $display("count: read %h resp %b", d, resp);
    endtask

    task automatic test_start();
        logic [1:0] resp; logic [31:0] d;
        int s0 = start_cnt, p0 = stop_cnt;
        axi_write(5'h00, 32'h1, 4'hF, 1, resp);
        repeat (3) tick();
        checks++;
        if ((start_cnt - s0) !== 1 || (stop_cnt - p0) !== 0) begin
            failures++; $display("FAIL start_pulse got start=%0d stop=%0d expected 1 0", start_cnt - s0, stop_cnt - p0);
        end
        axi_read(5'h00, d, resp);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL run_after_start got %h expected 00000001", d); end
        $display("start: pulses %0d run %h", start_cnt - s0, d);
    endtask

    task automatic test_stop_wins();
        logic [1:0] resp; logic [31:0] d;
        int s0 = start_cnt, p0 = stop_cnt;
        axi_write(5'h00, 32'h3, 4'hF, 0, resp);
        repeat (3) tick();
        checks++;
        if ((start_cnt - s0) !== 0 || (stop_cnt - p0) !== 1) begin
            failures++; $display("FAIL stop_wins got start=%0d stop=%0d expected 0 1", start_cnt - s0, stop_cnt - p0);
        end
        axi_read(5'h00, d, resp);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL run_after_stop got %h expected 00000000", d); end
        $display("stop: pulses %0d run %h", stop_cnt - p0, d);
    endtask

    task automatic test_irq();
        logic [1:0] resp; logic [31:0] d; bit st;
        core_irq_i = 1'b1;
        tick();
        checks++;
        if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_o_latency got %b expected 0", irq_o); end
        tick();
        checks++;
        if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_o_set got %b expected 1", irq_o); end
        core_irq_i = 1'b0;
        axi_read(5'h0C, d, resp);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL status_set got %h expected 00000001", d); end
        axi_write(5'h0C, 32'h1, 4'hF, 0, resp);
        tick();
        axi_read(5'h0C, d, resp);
        checks++;
        if ({d, irq_o} !== {32'h0, 1'b0}) begin
            failures++; $display("FAIL w1c_clear got %h/%b expected 00000000/0", d, irq_o);
        end
        // W1C commit lands on the same edge as a new core edge.
        s_awaddr = 5'h0C; s_wdata = 32'h1; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        checks++;
        if ({s_awready, s_wready} !== 2'b11) begin
            failures++; $display("FAIL w1c_race_ready got %b expected 11", {s_awready, s_wready});
        end
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; core_irq_i = 1'b1;
        wr_resp(0, resp, st);
        axi_read(5'h0C, d, resp);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL set_beats_w1c got %h expected 00000001", d); end
        core_irq_i = 1'b0;
        tick();
        axi_write(5'h0C, 32'h1, 4'hF, 0, resp);
        $display("irq: race status %h", d);
    endtask

    task automatic test_slverr();
        logic [1:0] resp; logic [31:0] d; bit st;
        rd_req(5'h1C);
        checks++;
        if ({s_arready, s_rvalid} !== 2'b01) begin
            failures++; $display("FAIL ar_blocked got %b expected 01", {s_arready, s_rvalid});
        end
        rd_resp(5, d, resp, st);
        checks++;
        if ({d, resp, st} !== {32'h0, 2'b10, 1'b1}) begin
            failures++; $display("FAIL rd_slverr got %h/%b/%0d expected 00000000/10/1", d, resp, st);
        end
        wr_req(5'h18, 32'hDEAD_BEEF, 4'hF, 0);
        wr_resp(5, resp, st);
        checks++;
        if ({resp, st} !== {2'b10, 1'b1}) begin
            failures++; $display("FAIL wr_slverr got %b/%0d expected 10/1", resp, st);
        end
        axi_read(5'h10, d, resp);
`ifdef TIMER_IRQ_MASK_EN
        checks++;
        if (resp !== 2'b00) begin failures++; $display("FAIL ier_mapped got %b expected 00", resp); end
`else
        checks++;
        if ({d, resp} !== {32'h0, 2'b10}) begin
            failures++; $display("FAIL ier_unmapped got %h/%b expected 00000000/10", d, resp);
        end
`endif
        $display("slverr: last resp %b", resp);
    endtask

`ifdef TIMER_IRQ_MASK_EN
    task automatic test_mask();
        logic [1:0] resp; logic [31:0] d;
        axi_write(5'h10, 32'h0, 4'hF, 0, resp);
        core_irq_i = 1'b1;
        repeat (3) tick();
        checks++;
        if (irq_o !== 1'b0) begin failures++; $display("FAIL masked_irq got %b expected 0", irq_o); end
        axi_read(5'h0C, d, resp);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL masked_pend got %h expected 00000001", d); end
        axi_write(5'h10, 32'h1, 4'hF, 0, resp);
        repeat (2) tick();
        checks++;
        if (irq_o !== 1'b1) begin failures++; $display("FAIL unmasked_irq got %b expected 1", irq_o); end
        axi_read(5'h10, d, resp);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL ier_read got %h expected 00000001", d); end
        core_irq_i = 1'b0;
        tick();
        axi_write(5'h0C, 32'h1, 4'hF, 0, resp);
        $display("mask: ier %h", d);
    endtask
`endif

    task automatic test_reset_mid();
        int n = 0;
        wr_req(5'h04, 32'h5555_AAAA, 4'hF, 0);
        while (!s_bvalid && n < 20) begin tick(); n++; end
        rstn = 1'b0;
        #1;
        checks++;
        if ({s_bvalid, s_awready} !== 2'b00) begin
            failures++; $display("FAIL reset_mid got %b expected 00", {s_bvalid, s_awready});
        end
        tick();
        rstn = 1'b1;
        tick();
        checks++;
        if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin
            failures++; $display("FAIL reset_mid_recover got %b expected 011", {s_bvalid, s_awready, s_wready});
        end
        $display("reset_mid: bvalid %b", s_bvalid);
    endtask

    initial begin
        rstn = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        cur_count_i = '0; core_irq_i = 1'b0;
        test_reset();
        test_load();
        test_count();
        test_start();
        test_stop_wins();
        test_irq();
        test_slverr();
`ifdef TIMER_IRQ_MASK_EN
        test_mask();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
